// File: rtl/result_readout_ctrl_mul.sv
// Drains result rows from CA_RAM to a valid/ready stream: READ -> CAPTURE -> HOLD per row.
// Optional READOUT_CLEAR_EN zeroes each row in CA_RAM as it is accepted downstream.
module result_readout_ctrl_mul #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_HOLD,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_num;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic                w_accept;

  assign w_accept = (r_state == S_HOLD) && r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (num_rows == '0) ? S_FINISH : S_READ;
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_HOLD;
      S_HOLD:    if (w_accept) w_next = r_out_last ? S_FINISH : S_READ;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ram_re = (r_state == S_READ);
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_FINISH);
`ifdef READOUT_CLEAR_EN
    ram_we = w_accept;
`else
    ram_we = 1'b0;
`endif
  end

  assign ram_wdata = '0;

  // Last-row flag is resolved at capture time so HOLD only needs the registered bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_num       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (num_rows != '0)) begin
            r_num  <= num_rows;
            r_addr <= '0;
          end
        end
        S_CAPTURE: begin
          r_out_data  <= ram_rdata;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_addr == (r_num - ADDR_W'(1)));
        end
        S_HOLD: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (!r_out_last) r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_addr  = r_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_result_readout_ctrl_mul.sv
// Scoreboard bench for result_readout_ctrl_mul: stimulus pushes expected beats, RAM addresses
// and done timing; a negedge monitor pops and compares. Honours READOUT_CLEAR_EN when defined.
module tb_result_readout_ctrl_mul;
  localparam int DW = 16;
  localparam int AW = 7;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] num_rows;
  logic [AW-1:0] ram_addr;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  result_readout_ctrl_mul #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_wdata(ram_wdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // CA_RAM emulation: registered read, one cycle latency
  logic [DW-1:0] ram [0:NR-1];
  logic [DW-1:0] mdl [0:NR-1];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram[ram_addr];
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  typedef struct { logic [DW-1:0] data; logic last; logic [AW-1:0] addr; } beat_t;
  typedef struct { int lat; int acc; } done_t;
  beat_t         beat_q[$];
  logic [AW-1:0] raddr_q[$];
  done_t         done_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, hs_cnt = 0, done_cnt = 0;
  int rdy_mode = 0, stall_beat = -1, stall_len = 0, stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always-1 or random, with an optional forced stall on one beat
  always @(posedge clk) begin
    #1;
    if (stall_beat >= 0 && hs_cnt == stall_beat && out_valid && stall_cnt < stall_len) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b1;
  end

  // Monitor
  logic [DW-1:0] held_d;
  logic          held_l;
  logic          held_v = 1'b0;
  always @(negedge clk) begin : mon
    beat_t         b;
    done_t         d;
    logic [AW-1:0] a;
    if (rst) held_v = 1'b0;
    else begin
      check("re_we_exclusive", 64'(ram_re & ram_we), 0);
      if (ram_re) begin
        if (raddr_q.size() == 0) check("unexpected_ram_re", 1, 0);
        else begin
          a = raddr_q.pop_front();
          check("ram_addr", 64'(ram_addr), 64'(a));
        end
      end
      if (out_valid) check("no_re_while_valid", 64'(ram_re), 0);
      if (held_v && out_valid) begin
        check("stall_data_stable", 64'(out_data), 64'(held_d));
        check("stall_last_stable", 64'(out_last), 64'(held_l));
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
`ifdef READOUT_CLEAR_EN
      if (ram_we) begin
        check("we_wdata_zero", 64'(ram_wdata), 0);
        check("we_only_on_handshake", 64'(out_valid && out_ready), 1);
      end
`else
      check("we_tied_low", 64'(ram_we), 0);
`endif
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (beat_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          b = beat_q.pop_front();
          check("out_data", 64'(out_data), 64'(b.data));
          check("out_last", 64'(out_last), 64'(b.last));
`ifdef READOUT_CLEAR_EN
          check("we_at_accept", 64'(ram_we), 1);
          check("we_addr", 64'(ram_addr), 64'(b.addr));
          mdl[b.addr] = '0;
`endif
        end
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          d = done_q.pop_front();
          if (d.lat >= 0) check("done_latency", 64'(cyc - d.acc), 64'(d.lat));
        end
      end
    end
  end

  task automatic load_random();
    for (int i = 0; i < NR; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      ram[i] <= v;
      mdl[i] = v;
    end
  endtask

  task automatic expect_drain(input int n, input int lat);
    for (int i = 0; i < n; i++) begin
      beat_q.push_back('{data: mdl[i], last: (i == n - 1), addr: AW'(i)});
      raddr_q.push_back(AW'(i));
    end
    done_q.push_back('{lat: lat, acc: cyc + 1});
  endtask

  task automatic issue(input int n, input int lat);
    @(posedge clk); #1;
    start = 1'b1;
    num_rows = AW'(n);
    expect_drain(n, lat);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base, k;
    base = done_cnt;
    k = 0;
    while (done_cnt == base && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == base) check("done_timeout", 0, 1);
    #1;
    check("idle_after_done", 64'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_addr"}, 64'(ram_addr), 0);
    check({tag, "_ram_re"}, 64'(ram_re), 0);
    check({tag, "_ram_we"}, 64'(ram_we), 0);
    check({tag, "_out_data"}, 64'(out_data), 0);
    check({tag, "_out_valid"}, 64'(out_valid), 0);
    check({tag, "_out_last"}, 64'(out_last), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, k;
    rst = 1'b1;
    start = 1'b0;
    num_rows = '0;
    load_random();
    #3;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Four rows at full rate
    ram[0] <= 16'h11; ram[1] <= 16'h22; ram[2] <= 16'h33; ram[3] <= 16'h44;
    mdl[0] = 16'h11; mdl[1] = 16'h22; mdl[2] = 16'h33; mdl[3] = 16'h44;
    issue(4, 12);
    wait_done(100);

    // Stall beat 1 for 5 cycles
    load_random();
    stall_beat = hs_cnt + 1; stall_len = 5; stall_cnt = 0;
    issue(3, -1);
    wait_done(100);
    check("stall_applied", 64'(stall_cnt), 5);
    stall_beat = -1;

    // Zero rows
    issue(0, 0);
    wait_done(10);

    // Reset while row 2 of 6 sits in HOLD
    load_random();
    base = hs_cnt;
    stall_beat = base + 2; stall_len = 1000; stall_cnt = 0;
    issue(6, -1);
    k = 0;
    while (!(hs_cnt == base + 2 && out_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("reached_row2_hold", 64'(hs_cnt == base + 2 && out_valid), 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    beat_q.delete(); raddr_q.delete(); done_q.delete();
    stall_beat = -1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    start = 1'b1;
    num_rows = AW'(2);
    expect_drain(2, 6);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);

    // Start re-pulsed while busy is ignored
    base = hs_cnt;
    issue(2, 6);
    @(posedge clk); #1;
    start = 1'b1; num_rows = AW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    check("ignored_start_beats", 64'(hs_cnt - base), 2);

    // Read the same rows twice (zeros the second time when clearing is enabled)
    load_random();
    issue(3, 9);
    wait_done(50);
    issue(3, 9);
    wait_done(50);

    // Maximum row count
    load_random();
    issue(NR - 1, 3 * (NR - 1));
    wait_done(3 * NR + 20);

    // Random drains with random backpressure
    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 2) == 0) load_random();
      issue($urandom_range(0, 12), -1);
      wait_done(400);
    end
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    check("beat_q_empty", 64'(beat_q.size()), 0);
    check("raddr_q_empty", 64'(raddr_q.size()), 0);
    check("done_q_empty", 64'(done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
